// File: rtl/register_bank_pkg.sv
// register_bank_pkg
//   Shared types and default parameter values for the register bank.
//   - state_e        : sequencer state (CLEAR sweep, RUN)
//   - DATA_WIDTH_DEF : default stored word width
//   - ADDR_WIDTH_DEF : default address width (depth = 2**ADDR_WIDTH_DEF)
package register_bank_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage : register_bank_pkg

// File: rtl/register_bank_if.sv
// register_bank_if
//   Bus bundle for the register bank: two read ports (A, B), one write
//   port (C) and the ready status.
//   - addra/addrb : read addresses          (master -> slave)
//   - dataa/datab : registered read data    (slave -> master)
//   - enc/addrc/datac : write enable/address/data (master -> slave)
//   - ready       : bank swept and accepting writes (slave -> master)
interface register_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dataa;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] datab;
  logic                  enc;
  logic [ADDR_WIDTH-1:0] addrc;
  logic [DATA_WIDTH-1:0] datac;
  logic                  ready;

  modport master (
    output addra, addrb, enc, addrc, datac,
    input  dataa, datab, ready
  );

  modport slave (
    input  addra, addrb, enc, addrc, datac,
    output dataa, datab, ready
  );

endinterface : register_bank_if

// File: rtl/register_bank.sv
// register_bank
//   2-read / 1-write register file with a power-up clear sweep.
//   After reset the bank sweeps every entry to zero (CLEAR), then enters
//   RUN where reads are registered (1-cycle latency) and a same-cycle
//   write to a read address is forwarded to that read port.
//   Ports:
//   - clock : rising-edge clock
//   - reset : synchronous active-high reset
//   - bus   : register_bank_if slave modport (addra/dataa, addrb/datab,
//             enc/addrc/datac, ready)
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int ZERO_REG   = 1
) (
  input  logic            clock,
  input  logic            reset,
  register_bank_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q,   state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                  ready_q,   ready_d;
  logic [DATA_WIDTH-1:0] dataa_q,   dataa_d;
  logic [DATA_WIDTH-1:0] datab_q,   datab_d;

  // Storage has no reset; it is cleared only through the write port.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  we_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic                  wr_ok_s;
  logic                  zero_a_s;
  logic                  zero_b_s;

  // A RUN write is dropped when it targets the hardwired-zero entry.
  assign wr_ok_s  = bus.enc && ((ZERO_REG == 0) || (bus.addrc != '0));
  assign zero_a_s = (ZERO_REG != 0) && (bus.addra == '0);
  assign zero_b_s = (ZERO_REG != 0) && (bus.addrb == '0);

  // Next-state, write-port mux and read-port data selection.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    dataa_d   = '0;
    datab_d   = '0;
    we_s      = 1'b0;
    waddr_s   = '0;
    wdata_s   = '0;
    if (reset) begin
      // Entry 0 is cleared while reset is held; nothing else changes.
      state_d   = CLEAR;
      clr_ptr_d = '0;
      ready_d   = 1'b0;
      we_s      = 1'b1;
      waddr_s   = '0;
      wdata_s   = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          we_s      = 1'b1;
          waddr_s   = clr_ptr_q;
          wdata_s   = '0;
          clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
          if (clr_ptr_q == LAST_ADDR) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            state_d = CLEAR;
            ready_d = 1'b0;
          end
        end
        RUN: begin
          we_s    = wr_ok_s;
          waddr_s = bus.addrc;
          wdata_s = bus.datac;
          ready_d = 1'b1;
          // Forward the incoming write so a same-cycle read sees new data.
          if (wr_ok_s && (bus.addrc == bus.addra)) begin
            dataa_d = bus.datac;
          end else if (zero_a_s) begin
            dataa_d = '0;
          end else begin
            dataa_d = mem_q[bus.addra];
          end
          if (wr_ok_s && (bus.addrc == bus.addrb)) begin
            datab_d = bus.datac;
          end else if (zero_b_s) begin
            datab_d = '0;
          end else begin
            datab_d = mem_q[bus.addrb];
          end
        end
        default: begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    state_q   <= state_d;
    clr_ptr_q <= clr_ptr_d;
    ready_q   <= ready_d;
    dataa_q   <= dataa_d;
    datab_q   <= datab_d;
  end

  // Single write port into the storage array.
  always_ff @(posedge clock) begin
    if (we_s) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

  assign bus.dataa = dataa_q;
  assign bus.datab = datab_q;
  assign bus.ready = ready_q;

endmodule : register_bank

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 32, bit width of every stored word and data port.
REQ-002 Parameter ADDR_WIDTH, default 5, address width; depth DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter ZERO_REG, default 1, when 1 entry 0 is hardwired to zero.
REQ-004 Port clock  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port addra  input  ADDR_WIDTH  read port A address.
REQ-007 Port dataa  output  DATA_WIDTH  read port A data, registered.
REQ-008 Port addrb  input  ADDR_WIDTH  read port B address.
REQ-009 Port datab  output  DATA_WIDTH  read port B data, registered.
REQ-010 Port enc  input  1  write enable for port C.
REQ-011 Port addrc  input  ADDR_WIDTH  write address.
REQ-012 Port datac  input  DATA_WIDTH  write data.
REQ-013 Port ready  output  1  high when the bank accepts writes and returns stored data.

Function
REQ-014 The block SHALL have two states: CLEAR (sweeping entries to zero) and RUN.
REQ-015 In CLEAR, the block SHALL write zero to entry clr_ptr each cycle and increment clr_ptr.
- clr_ptr is ADDR_WIDTH bits wide.
- CLEAR->RUN occurs on the edge that clears entry DEPTH-1.
REQ-016 Sweep length SHALL be DEPTH cycles after reset deassertion; ready SHALL rise on the first RUN cycle and never fall except on reset.
REQ-017 In CLEAR, enc SHALL be ignored, and dataa/datab SHALL load zero each cycle.
REQ-018 In RUN, dataa SHALL load entry[addra] on each rising edge (1-cycle read latency); datab likewise for addrb.
REQ-019 In RUN with enc=1, entry[addrc] SHALL load datac on the rising edge.
REQ-020 Write-read bypass: with enc=1 and addrc==addra, dataa SHALL load datac (new data, not old); same rule for port B.
REQ-021 With ZERO_REG=1, writes to address 0 SHALL be discarded and bypass SHALL NOT apply; reads of address 0 SHALL return zero.
REQ-022 Reads on A and B to the same address SHALL return identical data in the same cycle.
REQ-023 Address fields SHALL be used unmodified; all DEPTH addresses are valid, with no wrap or truncation logic.

Reset
REQ-024 reset=1 at a rising edge SHALL force state=CLEAR, clr_ptr=0, ready=0, dataa=0, datab=0.
REQ-025 While reset is held, no entry SHALL change except entry 0, which is cleared.
REQ-026 Reset asserted mid-sweep or in RUN SHALL restart the sweep from entry 0.
REQ-027 Storage SHALL have no reset term other than the sweep, so it maps to RAM/LUTRAM.

Structure
REQ-028 Package register_bank_pkg SHALL hold:
- state enum (CLEAR, RUN);
- default parameter constants DATA_WIDTH_DEF=32, ADDR_WIDTH_DEF=5.
REQ-029 The block SHALL be a single module; the storage array, clear sequencer and bypass muxes are inline, with no sub-module.

Verification
REQ-030 Reset 1 cycle, then idle -> ready=0 for 32 cycles, ready=1 on cycle 33; reading all 32 addresses returns 0.
REQ-031 RUN sequence:
- write addr 7 = 0xDEADBEEF;
- next cycle, read A=7 and B=7 -> both ports show 0xDEADBEEF one cycle later.
REQ-032 Same-cycle write addr 3 = 0x12345678 with addra=3, addrb=4 (addr 4 holds 0x1) -> dataa=0x12345678, datab=0x1.
REQ-033 ZERO_REG=1: write addr 0 = 0xFFFFFFFF, then read A=0 -> dataa=0 on the write cycle and on later reads.
REQ-034 Reset mid-RUN and mid-sweep:
- write addr 9 = 0xA5A5A5A5, then assert reset at sweep cycle 10 (and separately in RUN);
- required response: ready drops, full 32-cycle sweep restarts, and addr 9 reads 0.
REQ-035 Parameter instance DATA_WIDTH=64, ADDR_WIDTH=3, ZERO_REG=0:
- sweep lasts 8 cycles;
- write addr 0 = 0x0123456789ABCDEF -> read back 0x0123456789ABCDEF.
